// File: rtl/fpu_addsub_arbiter_if.sv
// Bundle between NUM_REQ requesters, the arbiter and one shared add/sub FPU.
// Carries request, FPU issue, FPU result and response signals only.
// Requests are valid/ready; responses are pulses with no backpressure.
interface fpu_addsub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = $clog2(FPU_LAT + 2) + 1
);
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [NUM_REQ-1:0]    i_req_op;
  logic [NUM_REQ*32-1:0] i_req_a;
  logic [NUM_REQ*32-1:0] i_req_b;
  logic                  i_hold;
  logic                  o_fpu_op;
  logic [31:0]           o_fpu_a;
  logic [31:0]           o_fpu_b;
  logic [31:0]           i_fpu_s;
  logic                  o_rsp_valid;
  logic [ID_W-1:0]       o_rsp_id;
  logic [31:0]           o_rsp_data;
  logic [CNT_W-1:0]      o_inflight;

  // Arbiter side.
  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b, i_hold, i_fpu_s,
    output o_req_ready, o_fpu_op, o_fpu_a, o_fpu_b,
           o_rsp_valid, o_rsp_id, o_rsp_data, o_inflight
  );

  // Requester / FPU environment side.
  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b, i_hold, i_fpu_s,
    input  o_req_ready, o_fpu_op, o_fpu_a, o_fpu_b,
           o_rsp_valid, o_rsp_id, o_rsp_data, o_inflight
  );
endinterface

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin share of one add/sub FPU between NUM_REQ butterfly lanes.
// Latency: grant to response pulse is FPU_LAT+1 cycles, one grant per cycle.
// Backpressure: i_hold blocks new grants only; responses cannot be stalled.
module fpu_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = $clog2(FPU_LAT + 2) + 1
) (
  input logic              i_clk,
  input logic              i_rst_n,
  fpu_addsub_arbiter_if.slave bus
);

  logic [ID_W-1:0]  p_q, p_d;
  logic             gnt;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  cand;

  logic             fpu_op_q;
  logic [31:0]      fpu_a_q, fpu_b_q;

  logic             tag_vld_q [FPU_LAT];
  logic [ID_W-1:0]  tag_id_q  [FPU_LAT];

  logic             rsp_vld_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [31:0]      rsp_dat_q;

  logic [CNT_W-1:0] inflight_q, inflight_d;

  // Search upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    gnt    = 1'b0;
    gnt_id = '0;
    cand   = '0;
    if (i_rst_n && !bus.i_hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = ID_W'((int'(p_q) + i) % NUM_REQ);
        if (!gnt && bus.i_req_valid[cand]) begin
          gnt    = 1'b1;
          gnt_id = cand;
        end
      end
    end
  end

  assign bus.o_req_ready = gnt ? (NUM_REQ'(1) << gnt_id) : '0;

  // Pointer moves just past the winner; unchanged when nobody is granted.
  always_comb begin
    p_d = p_q;
    if (gnt) begin
      p_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Pending count: up on grant, down on the response pulse, both cancel.
  always_comb begin
    inflight_d = inflight_q;
    if (gnt && !rsp_vld_q) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!gnt && rsp_vld_q) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  // Pointer, issue registers and counter; operands hold on idle cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_q        <= '0;
      fpu_op_q   <= 1'b0;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      inflight_q <= '0;
    end else begin
      p_q        <= p_d;
      inflight_q <= inflight_d;
      if (gnt) begin
        fpu_op_q <= bus.i_req_op[gnt_id];
        fpu_a_q  <= bus.i_req_a[32*gnt_id +: 32];
        fpu_b_q  <= bus.i_req_b[32*gnt_id +: 32];
      end
    end
  end

  // Tag shift register aligned so its last stage matches i_fpu_s.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FPU_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= gnt;
      tag_id_q[0]  <= gnt_id;
      for (int i = 1; i < FPU_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  // Capture the FPU result with its owner id; pulse valid for one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_dat_q <= '0;
    end else begin
      rsp_vld_q <= tag_vld_q[FPU_LAT-1];
      if (tag_vld_q[FPU_LAT-1]) begin
        rsp_id_q  <= tag_id_q[FPU_LAT-1];
        rsp_dat_q <= bus.i_fpu_s;
      end
    end
  end

  assign bus.o_fpu_op    = fpu_op_q;
  assign bus.o_fpu_a     = fpu_a_q;
  assign bus.o_fpu_b     = fpu_b_q;
  assign bus.o_rsp_valid = rsp_vld_q;
  assign bus.o_rsp_id    = rsp_id_q;
  assign bus.o_rsp_data  = rsp_dat_q;
  assign bus.o_inflight  = inflight_q;

endmodule
